sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Single-clock, fully parametrised FIFO: the successor to our dual-clock FIFO for same-domain buffering. It adds programmable almost-full and almost-empty thresholds, a fill count, and a first-word-fall-through (FWFT) mode selectable at elaboration. It also adds separate overflow and underflow pulses, a sticky error flag and a synchronous flush. It sits between any producer and consumer sharing `clk_i`.

## Interface
- `WIDTH`, 8: data word width, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `ADDRESS_WIDTH`, `$clog2(DEPTH)`: memory address width.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.
- `AF_LEVEL`, `DEPTH-2`: almost-full threshold, 1..DEPTH.
- `AE_LEVEL`, 2: almost-empty threshold, 0..DEPTH-1.
- `clk_i`  in  1: single clock; all logic on the rising edge.
- `rst_n_i`  in  1: reset, asynchronous and active-low.
- `clr_i`  in  1: synchronous flush.
- `wr_en_i`  in  1: write request.
- `wdata_i`  in  WIDTH: write data.
- `rd_en_i`  in  1: read request.
- `rdata_o`  out  WIDTH: read data.
- `full_o`, `empty_o`  out  1 each: fill-state flags.
- `almost_full_o`, `almost_empty_o`  out  1 each: threshold flags.
- `count_o`  out  ADDRESS_WIDTH+1: current occupancy, 0..DEPTH.
- `overflow_o`, `underflow_o`  out  1 each: single-cycle rejected-access pulses.
- `error_o`  out  1: sticky OR of overflow and underflow.

## Operation
- **Storage.** DEPTH×WIDTH memory with write pointer `wp` and read pointer `rp`.
  - Both pointers are ADDRESS_WIDTH+1 bits and wrap naturally modulo 2·DEPTH.
  - The memory index is the pointer's low ADDRESS_WIDTH bits.
- **Write acceptance.** A write is accepted iff `wr_en_i && !full_o`.
  - The word is stored at `mem[wp]` and `wp` increments.
- **Read acceptance.** A read is accepted iff `rd_en_i && !empty_o`.
  - `rp` increments.
- **Simultaneous read and write.**
  - Not full and not empty: both are accepted and `count_o` is unchanged.
  - When full: the read is accepted and the write is rejected.
  - When empty: the write is accepted and the read is rejected.
  - No pass-through in either case.
- **Count and flags.** `count_o` is a register: +1 on write only, −1 on read only. All flags are registered, decoded from the next count value:
  - `full_o` = (count == DEPTH)
  - `empty_o` = (count == 0)
  - `almost_full_o` = (count ≥ AF_LEVEL)
  - `almost_empty_o` = (count ≤ AE_LEVEL)
- **Read data, FWFT=0.**
  - `rdata_o` is a register loaded with `mem[rp]` on an accepted read.
  - It holds its value otherwise, including on rejected reads.
- **Read data, FWFT=1.**
  - `rdata_o = mem[rp[ADDRESS_WIDTH-1:0]]` combinationally, so the head word is visible whenever `!empty_o`.
  - `rd_en_i` acts as a pop.
  - Value while empty is don't-care; the bench must not check it.
- **Error reporting.**
  - Rejected write (`wr_en_i && full_o`): `overflow_o` = 1 for exactly the next cycle.
  - Rejected read (`rd_en_i && empty_o`): `underflow_o` = 1 for exactly the next cycle.
  - `error_o` sets on either condition and holds until reset or `clr_i`.
- **Flush (`clr_i`).** Has priority over `wr_en_i`/`rd_en_i` in the same cycle.
  - Pointers and `count_o` go to 0; flags return to reset values.
  - `overflow_o`, `underflow_o` and `error_o` go to 0.
  - Memory contents are not cleared.
  - FWFT=0 `rdata_o` holds its value.
- **Reset values.**
  - `rdata_o` = 0; `count_o` = 0.
  - `empty_o` = 1; `full_o` = 0.
  - `almost_empty_o` = 1; `almost_full_o` = 0.
  - `overflow_o` = 0; `underflow_o` = 0; `error_o` = 0.

## Timing
- **Write to flags.** A write accepted at edge N makes `empty_o` = 0 and the new `count_o` visible after edge N.
- **Write to data, FWFT=1.** Head data is valid in the same cycle `empty_o` falls, i.e. 1-cycle write-to-read latency.
- **Write to data, FWFT=0.**
  - The consumer may assert `rd_en_i` in the cycle after edge N.
  - Data appears on `rdata_o` after the edge on which that read is accepted.
- **Throughput.** One write and one read per cycle sustained.
- **Reset.** `rst_n_i` low clears all state immediately, mid-operation included, with no clock required. Operation resumes on the first rising edge after deassertion.
- **Wrap.** Pointers wrap after 2·DEPTH operations. Full/empty detection must remain correct across any number of wraps.

## Test plan
- **Fill and overflow.** DEPTH=16, WIDTH=8: write 0x00..0x0F on 16 consecutive cycles, then one more write.
  - `count_o` reaches 16 and `full_o` = 1.
  - `almost_full_o` rises when count becomes 14.
  - The 17th write is rejected: `overflow_o` pulses for 1 cycle, `error_o` stays 1, contents are unchanged.
- **Drain and underflow.** From full, read 17 times.
  - FWFT=0: `rdata_o` returns 0x00..0x0F in order, each one edge after the accepted read.
  - `empty_o` rises after the 16th read; `almost_empty_o` rises at count 2.
  - The 17th read pulses `underflow_o`.
- **Simultaneous access and wrap.** Preload 8 words, then assert `wr_en_i` and `rd_en_i` together for 40 cycles with incrementing data.
  - `count_o` stays 8.
  - Output order is strictly sequential across the pointer wrap.
- **Simultaneous access at boundaries.**
  - At full, read+write together: count becomes 15 and `overflow_o` pulses.
  - At empty, read+write together: count becomes 1 and `underflow_o` pulses.
- **FWFT mode.** FWFT=1: write 0xA5 into an empty FIFO.
  - `rdata_o` = 0xA5 in the cycle `empty_o` falls.
  - Pop with `rd_en_i`: `empty_o` = 1 after the edge.
- **Reset and flush mid-operation.**
  - With 5 words stored and `error_o` = 1, assert `clr_i` together with `wr_en_i` for one cycle: `count_o` = 0, `empty_o` = 1, `error_o` = 0, and the write is ignored.
  - Refill 3 words, then pulse `rst_n_i` low between clock edges: all outputs take their reset values immediately.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, threshold flags, optional
// first-word-fall-through read port, rejected-access pulses and synchronous flush.
module sync_fifo_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int FWFT          = 0,
  parameter int AF_LEVEL      = DEPTH - 2,
  parameter int AE_LEVEL      = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [ADDRESS_WIDTH:0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic                     error_o
);

  typedef logic [ADDRESS_WIDTH:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AF_P    = ptr_t'(AF_LEVEL);
  localparam ptr_t AE_P    = ptr_t'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wp, rp;
  ptr_t             count_q, count_nxt;
  logic             full_q, empty_q, af_q, ae_q;
  logic             ovf_q, unf_q, err_q;
  logic             wr_ok, rd_ok;
  logic [ADDRESS_WIDTH-1:0] wp_idx, rp_idx;

  assign wr_ok  = wr_en_i && !full_q;
  assign rd_ok  = rd_en_i && !empty_q;
  assign wp_idx = wp[ADDRESS_WIDTH-1:0];
  assign rp_idx = rp[ADDRESS_WIDTH-1:0];

  // NOTE: default assignment first so every path drives count_nxt and no latch is inferred.
  always_comb begin
    count_nxt = count_q;
    if (clr_i)                 count_nxt = '0;
    else if (wr_ok && !rd_ok)  count_nxt = count_q + 1'b1;
    else if (rd_ok && !wr_ok)  count_nxt = count_q - 1'b1;
  end

  // Flags decode the next count, so a flush (count_nxt = 0) restores their reset values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      if (clr_i) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (wr_ok) wp <= wp + 1'b1;
        if (rd_ok) rp <= rp + 1'b1;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_P);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_P);
      ae_q    <= (count_nxt <= AE_P);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else if (clr_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= wr_en_i && full_q;
      unf_q <= rd_en_i && empty_q;
      err_q <= err_q || (wr_en_i && full_q) || (rd_en_i && empty_q);
    end
  end

  // NOTE: storage carries no reset; only pointers and count define which words are valid.
  always_ff @(posedge clk_i) begin
    if (wr_ok && !clr_i) mem[wp_idx] <= wdata_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata_o = mem[rp_idx];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)             rdata_q <= '0;
        else if (rd_ok && !clr_i) rdata_q <= mem[rp_idx];
      end
      assign rdata_o = rdata_q;
    end
  endgenerate

  // Occupancy implied by the wrapping pointers must always match the count register.
  assert property (@(posedge clk_i) disable iff (!rst_n_i) count_q == ptr_t'(wp - rp));

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench: a registered-read and an FWFT instance share stimulus
// and are checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk_i = 1'b0;
  logic             rst_n_i, clr_i, wr_en_i, rd_en_i;
  logic [WIDTH-1:0] wdata_i;

  logic [WIDTH-1:0] rdata0, rdata1;
  logic             full0, empty0, af0, ae0, ovf0, unf0, err0;
  logic             full1, empty1, af1, ae1, ovf1, unf1, err1;
  logic [AW:0]      count0, count1;

  int n_vec = 0;
  int n_mis = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  logic             m_ovf = 1'b0, m_unf = 1'b0, m_err = 1'b0;

  always #5 clk_i = ~clk_i;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_reg (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(clr_i), .wr_en_i(wr_en_i),
    .wdata_i(wdata_i), .rd_en_i(rd_en_i), .rdata_o(rdata0),
    .full_o(full0), .empty_o(empty0), .almost_full_o(af0), .almost_empty_o(ae0),
    .count_o(count0), .overflow_o(ovf0), .underflow_o(unf0), .error_o(err0)
  );

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(clr_i), .wr_en_i(wr_en_i),
    .wdata_i(wdata_i), .rd_en_i(rd_en_i), .rdata_o(rdata1),
    .full_o(full1), .empty_o(empty1), .almost_full_o(af1), .almost_empty_o(ae1),
    .count_o(count1), .overflow_o(ovf1), .underflow_o(unf1), .error_o(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input logic [AW:0] cnt, input logic f, e,
                           input logic af, ae, ov, un, er);
    int n;
    n = mq.size();
    check({tag, " count"},    32'(cnt), n);
    check({tag, " full"},     32'(f),   32'(n == DEPTH));
    check({tag, " empty"},    32'(e),   32'(n == 0));
    check({tag, " afull"},    32'(af),  32'(n >= AF));
    check({tag, " aempty"},   32'(ae),  32'(n <= AE));
    check({tag, " overflow"}, 32'(ov),  32'(m_ovf));
    check({tag, " underflw"}, 32'(un),  32'(m_unf));
    check({tag, " error"},    32'(er),  32'(m_err));
  endtask

  task automatic check_both(input string tag);
    check_dut({tag, "/reg"},  count0, full0, empty0, af0, ae0, ovf0, unf0, err0);
    check_dut({tag, "/fwft"}, count1, full1, empty1, af1, ae1, ovf1, unf1, err1);
  endtask

  // One clock of stimulus; the model advances by the FIFO's acceptance rules.
  task automatic cyc(input string tag, input logic wr, rd, clr, input logic [WIDTH-1:0] d);
    bit full_pre, empty_pre;
    wr_en_i   = wr;
    rd_en_i   = rd;
    clr_i     = clr;
    wdata_i   = d;
    full_pre  = (mq.size() == DEPTH);
    empty_pre = (mq.size() == 0);
    @(posedge clk_i);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    clr_i   = 1'b0;
    if (clr) begin
      mq.delete();
      exp_q1.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_err = 1'b0;
    end else begin
      m_ovf = wr && full_pre;
      m_unf = rd && empty_pre;
      m_err = m_err | m_ovf | m_unf;
      if (rd && !empty_pre) exp_q0.push_back(mq.pop_front());
      if (wr && !full_pre) begin
        mq.push_back(d);
        exp_q1.push_back(d);
      end
    end
    check_both(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q0.delete();
    exp_q1.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_err = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents read data.
  initial begin
    bit pop0, pop1;
    forever begin
      @(negedge clk_i);
      pop0 = rst_n_i && rd_en_i && !clr_i && !empty0;
      pop1 = rst_n_i && rd_en_i && !clr_i && !empty1;
      if (pop1) begin
        if (exp_q1.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL fwft head: got 0x%0h, expected no word at %0t", rdata1, $time);
        end else check("fwft head", 32'(rdata1), 32'(exp_q1.pop_front()));
      end
      @(posedge clk_i);
      #2;
      if (pop0) begin
        if (exp_q0.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL reg rdata: got 0x%0h, expected no word at %0t", rdata0, $time);
        end else check("reg rdata", 32'(rdata0), 32'(exp_q0.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    rst_n_i = 1'b0;
    clr_i   = 1'b0;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    wdata_i = '0;
    model_reset();
    #12;
    check_both("reset");
    check("reset rdata", 32'(rdata0), 32'h0);
    rst_n_i = 1'b1;

    // Fill, then one rejected write.
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 1'b0, 1'b0, WIDTH'(i));
    cyc("overflow", 1'b1, 1'b0, 1'b0, 8'hEE);
    cyc("ovf idle", 1'b0, 1'b0, 1'b0, 8'h00);

    // Drain in order, then one rejected read.
    for (int i = 0; i <= DEPTH; i++) cyc("drain", 1'b0, 1'b1, 1'b0, 8'h00);
    cyc("unf idle", 1'b0, 1'b0, 1'b0, 8'h00);

    // Preload 8, then concurrent access across several pointer wraps.
    for (int i = 0; i < 8; i++) cyc("preload", 1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) cyc("rw steady", 1'b1, 1'b1, 1'b0, 8'h48 + 8'(i));

    // Concurrent access at full and at empty.
    for (int i = 0; i < 8; i++) cyc("top up", 1'b1, 1'b0, 1'b0, 8'h90 + 8'(i));
    cyc("rw at full", 1'b1, 1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 15; i++) cyc("empty out", 1'b0, 1'b1, 1'b0, 8'h00);
    cyc("rw at empty", 1'b1, 1'b1, 1'b0, 8'hC3);
    cyc("pop one", 1'b0, 1'b1, 1'b0, 8'h00);

    // Fall-through: head word visible in the cycle empty falls.
    cyc("fwft wr", 1'b1, 1'b0, 1'b0, 8'hA5);
    check("fwft a5 data", 32'(rdata1), 32'hA5);
    cyc("fwft pop", 1'b0, 1'b1, 1'b0, 8'h00);

    // Randomised traffic: write-biased phase then read-biased phase, rare flushes.
    for (int i = 0; i < 400; i++) begin
      int wbias;
      wbias = (i < 200) ? 70 : 30;
      cyc("random", $urandom_range(0, 99) < wbias, $urandom_range(0, 99) < (100 - wbias),
          $urandom_range(0, 63) == 0, 8'($urandom));
    end

    // Flush with a concurrent write while holding words and a set error flag.
    cyc("pre flush", 1'b0, 1'b0, 1'b1, 8'h00);
    cyc("set err", 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cyc("five", 1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
    cyc("clr+wr", 1'b1, 1'b0, 1'b1, 8'h77);
    cyc("after clr", 1'b0, 1'b1, 1'b0, 8'h00);

    // Refill, then asynchronous reset between edges.
    for (int i = 0; i < 3; i++) cyc("refill", 1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
    #2;
    rst_n_i = 1'b0;
    model_reset();
    #1;
    check_both("async rst");
    check("async rst rdata", 32'(rdata0), 32'h0);
    #2;
    rst_n_i = 1'b1;
    cyc("resume wr", 1'b1, 1'b0, 1'b0, 8'h5A);
    cyc("resume rd", 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc("tail", 1'b0, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
